// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: state encoding, PS/2 command bytes and clock-derived timing constants
// shared by the host-to-device transmitter and its line synchroniser.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, WAIT_FIRST, SHIFT, ACK, RELEASE} state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    function automatic int inhibit_cyc(input int f);
        return f / 10000;
    endfunction

    function automatic int req_cyc(input int f);
        return f / 1000000;
    endfunction

    function automatic int start_to(input int f);
        return 15 * f / 1000;
    endfunction

    function automatic int xfer_to(input int f);
        return 2 * f / 1000;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and raw PS/2 pin signals of the host transmitter.
interface ps2_host_tx_if;
    logic       send_cmd;
    logic [7:0] cmd_data;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output send_cmd, cmd_data, ps2_clk_in, ps2_dat_in,
        input  ps2_clk_drive_low, ps2_dat_drive_low, busy, done, error
    );

    modport slave (
        input  send_cmd, cmd_data, ps2_clk_in, ps2_dat_in,
        output ps2_clk_drive_low, ps2_dat_drive_low, busy, done, error
    );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronisers for the PS/2 clock and data pins plus a registered
// one-cycle strobe on each falling edge of the synchronised clock.
module ps2_line_sync (
    input  logic Clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_level,
    output logic dat_level,
    output logic clk_fall
);
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;

    assign clk_level = clk_sync[1];
    assign dat_level = dat_sync[1];

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
            clk_fall <= clk_prev & ~clk_sync[1];
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device with the request-to-send sequence
// and reports the device's line-level acknowledge; drive-low outputs feed open-drain pads.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input logic         Clock,
    input logic         reset,
    ps2_host_tx_if.slave bus
);
    localparam int TW = $clog2(start_to(CLOCK_FREQUENCY)) + 1;
    localparam logic [TW-1:0] INH_END = TW'(inhibit_cyc(CLOCK_FREQUENCY) - 1);
    localparam logic [TW-1:0] REQ_END = TW'(req_cyc(CLOCK_FREQUENCY) - 1);
    localparam logic [TW-1:0] STO_END = TW'(start_to(CLOCK_FREQUENCY) - 1);
    localparam logic [TW-1:0] XTO_END = TW'(xfer_to(CLOCK_FREQUENCY) - 1);

    state_t        state, state_n;
    logic [9:0]    shift;
    logic [3:0]    cnt;
    logic [TW-1:0] tmr;
    logic          nack;
    logic          clk_level, dat_level, clk_fall, xto;
    logic          clk_dl_n, dat_dl_n, busy_n, done_n, error_n;

    ps2_line_sync u_sync (
        .Clock     (Clock),
        .reset     (reset),
        .ps2_clk   (bus.ps2_clk_in),
        .ps2_dat   (bus.ps2_dat_in),
        .clk_level (clk_level),
        .dat_level (dat_level),
        .clk_fall  (clk_fall)
    );

    // the transfer timer runs uninterrupted from edge 1 through SHIFT, ACK and RELEASE
    assign xto = (state == SHIFT || state == ACK || state == RELEASE) && tmr == XTO_END;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            shift                 <= '0;
            cnt                   <= '0;
            tmr                   <= '0;
            nack                  <= 1'b0;
            bus.ps2_clk_drive_low <= 1'b0;
            bus.ps2_dat_drive_low <= 1'b0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.error             <= 1'b0;
        end else begin
            state <= state_n;
            tmr   <= (state == IDLE || (state_n != state && state inside {INHIBIT, REQUEST, WAIT_FIRST}))
                     ? '0 : tmr + TW'(1);
            if (state == IDLE && bus.send_cmd)
                shift <= {1'b1, ~^bus.cmd_data, bus.cmd_data};
            else if (clk_fall && (state == WAIT_FIRST || state == SHIFT))
                shift <= {1'b1, shift[9:1]};
            cnt  <= state == IDLE ? '0
                  : clk_fall && cnt != 4'd11 && state inside {WAIT_FIRST, SHIFT, ACK} ? cnt + 4'd1 : cnt;
            nack <= state == IDLE ? 1'b0 : state == ACK && clk_fall ? dat_level : nack;
            bus.ps2_clk_drive_low <= clk_dl_n;
            bus.ps2_dat_drive_low <= dat_dl_n;
            bus.busy              <= busy_n;
            bus.done              <= done_n;
            bus.error             <= error_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (bus.send_cmd) state_n = INHIBIT;
            INHIBIT:    if (tmr == INH_END) state_n = REQUEST;
            REQUEST:    if (tmr == REQ_END) state_n = WAIT_FIRST;
            WAIT_FIRST: if (clk_fall) state_n = SHIFT;
                        else if (tmr == STO_END) state_n = IDLE;
            SHIFT:      if (xto) state_n = IDLE;
                        else if (clk_fall && cnt == 4'd9) state_n = ACK;
            ACK:        if (xto) state_n = IDLE;
                        else if (clk_fall) state_n = RELEASE;
            RELEASE:    if (xto || (clk_level && dat_level)) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    // outputs are decoded from the next state so they register in step with it
    always_comb begin
        clk_dl_n = state_n == INHIBIT || state_n == REQUEST;
        dat_dl_n = state_n == REQUEST || state_n == WAIT_FIRST
                   || (state_n == SHIFT && (clk_fall ? ~shift[0] : bus.ps2_dat_drive_low));
        busy_n   = state_n != IDLE;
        done_n   = state != IDLE && state_n == IDLE;
        error_n  = done_n && (state != RELEASE || xto || nack);
    end
endmodule
